int_iq_age_scheduler: RTL and testbench

- Slot/age controller for an 8-entry integer issue queue.
- Allocates free slots to up to 2 dispatched instructions per cycle and tracks operand readiness per slot.
- Keeps each entry's age as an exact relative rank, selects the two oldest ready entries for the two integer issue ports, and frees slots on issue acceptance or flush.
- Sits between rename/dispatch and the integer FUs. The payload RAM is external and indexed by the slot IDs this block produces.

---
 rtl/int_iq_age_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_int_iq_age_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/int_iq_age_scheduler.sv
// int_iq_age_scheduler
//   Slot/age controller for an 8-entry integer issue queue. Allocates up to two
//   free slots per cycle to dispatching instructions, tracks operand readiness,
//   keeps an exact relative age rank per entry (age = number of younger valid
//   entries) and offers the two oldest ready entries to the two issue ports.
// Ports
//   clk, rst            : clock, synchronous active-high reset (beats flush)
//   flush               : clears every entry at the next edge
//   disp_valid/src_ready: per-lane dispatch request / operands ready (lane 0 older)
//   disp_ready          : at least two free slots
//   disp_slot_0/1       : lowest / second-lowest free slot (0 when none)
//   wake_mask           : per-slot operand wakeup
//   issue_valid/slot_0  : oldest ready entry; issue_accept_0 frees it
//   issue_valid/slot_1  : second-oldest ready entry; issue_accept_1 frees it
//   occupancy           : number of valid entries
module int_iq_age_scheduler #(
  parameter int IQ_DEPTH = 8,
  parameter int SLOT_W   = 3,
  parameter int AGE_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [1:0]          disp_valid,
  input  logic [1:0]          disp_src_ready,
  output logic                disp_ready,
  output logic [SLOT_W-1:0]   disp_slot_0,
  output logic [SLOT_W-1:0]   disp_slot_1,
  input  logic [IQ_DEPTH-1:0] wake_mask,
  output logic                issue_valid_0,
  output logic [SLOT_W-1:0]   issue_slot_0,
  input  logic                issue_accept_0,
  output logic                issue_valid_1,
  output logic [SLOT_W-1:0]   issue_slot_1,
  input  logic                issue_accept_1,
  output logic [AGE_W-1:0]    occupancy
);

  logic [IQ_DEPTH-1:0]            valid_q, valid_d, ready_q, ready_d;
  logic [IQ_DEPTH-1:0][AGE_W-1:0] age_q, age_d;
  logic [AGE_W-1:0]               occ_q, occ_d;

  logic                found0, found1;
  logic [IQ_DEPTH-1:0] cand, iss_mask;
  logic                iss0, iss1, acc0, acc1;
  logic [AGE_W-1:0]    n_disp, n_iss;

  assign occupancy  = occ_q;
  assign disp_ready = (AGE_W'(IQ_DEPTH) - occ_q) >= AGE_W'(2);

  // Free-slot search looks at registered valid only, so a slot freed this
  // cycle is not handed out again until the next one.
  always_comb begin
    disp_slot_0 = '0;
    disp_slot_1 = '0;
    found0      = 1'b0;
    found1      = 1'b0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (!valid_q[i]) begin
        if (!found0) begin
          disp_slot_0 = SLOT_W'(i);
          found0      = 1'b1;
        end else if (!found1) begin
          disp_slot_1 = SLOT_W'(i);
          found1      = 1'b1;
        end
      end
    end
  end

  // Ages are unique, so a candidate's rank among ready entries is simply the
  // number of ready entries that are older than it.
  assign cand = valid_q & ready_q;

  always_comb begin
    logic [AGE_W-1:0] nold;
    issue_valid_0 = 1'b0;
    issue_slot_0  = '0;
    issue_valid_1 = 1'b0;
    issue_slot_1  = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      nold = '0;
      for (int j = 0; j < IQ_DEPTH; j++)
        if (cand[j] && (age_q[j] > age_q[i])) nold = nold + 1'b1;
      if (cand[i] && nold == AGE_W'(0)) begin
        issue_valid_0 = 1'b1;
        issue_slot_0  = SLOT_W'(i);
      end
      if (cand[i] && nold == AGE_W'(1)) begin
        issue_valid_1 = 1'b1;
        issue_slot_1  = SLOT_W'(i);
      end
    end
  end

  assign iss0     = issue_valid_0 & issue_accept_0;
  assign iss1     = issue_valid_1 & issue_accept_1;
  assign iss_mask = ({IQ_DEPTH{iss0}} & (IQ_DEPTH'(1) << issue_slot_0))
                  | ({IQ_DEPTH{iss1}} & (IQ_DEPTH'(1) << issue_slot_1));
  assign acc0     = disp_valid[0] & disp_ready;
  assign acc1     = disp_valid[1] & disp_ready;
  assign n_disp   = AGE_W'(acc0) + AGE_W'(acc1);
  assign n_iss    = AGE_W'(iss0) + AGE_W'(iss1);

  always_comb begin
    logic [AGE_W-1:0] ny;
    valid_d = valid_q;
    ready_d = ready_q;
    age_d   = age_q;
    occ_d   = occ_q;
    ny      = '0;
    if (flush) begin
      valid_d = '0;
      ready_d = '0;
      age_d   = '0;
      occ_d   = '0;
    end else begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        if (valid_q[i]) begin
          if (iss_mask[i]) begin
            valid_d[i] = 1'b0;
            ready_d[i] = 1'b0;
            age_d[i]   = '0;
          end else begin
            // New dispatches are younger than every survivor; issued entries
            // that were younger than this one no longer count.
            ny = '0;
            if (iss0 && (age_q[issue_slot_0] < age_q[i])) ny = ny + 1'b1;
            if (iss1 && (age_q[issue_slot_1] < age_q[i])) ny = ny + 1'b1;
            ready_d[i] = ready_q[i] | wake_mask[i];
            age_d[i]   = age_q[i] + n_disp - ny;
          end
        end
      end
      if (acc0) begin
        valid_d[disp_slot_0] = 1'b1;
        ready_d[disp_slot_0] = disp_src_ready[0] | wake_mask[disp_slot_0];
        age_d[disp_slot_0]   = acc1 ? AGE_W'(1) : AGE_W'(0);
      end
      if (acc1) begin
        valid_d[disp_slot_1] = 1'b1;
        ready_d[disp_slot_1] = disp_src_ready[1] | wake_mask[disp_slot_1];
        age_d[disp_slot_1]   = '0;
      end
      occ_d = occ_q + n_disp - n_iss;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      ready_q <= '0;
      age_q   <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      age_q   <= age_d;
      occ_q   <= occ_d;
    end
  end

  // Invariant checks: ages form a permutation of 0..occupancy-1.
  logic age_err;
  always_comb begin
    age_err = 1'b0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (valid_q[i] && (age_q[i] >= occ_q)) age_err = 1'b1;
      for (int j = i + 1; j < IQ_DEPTH; j++)
        if (valid_q[i] && valid_q[j] && (age_q[i] == age_q[j])) age_err = 1'b1;
    end
  end

  a_age_unique: assert property (@(posedge clk) disable iff (rst) !age_err);
  a_occ_count:  assert property (@(posedge clk) disable iff (rst)
                                 occ_q == AGE_W'($countones(valid_q)));
  a_lane_order: assert property (@(posedge clk) disable iff (rst) disp_valid != 2'b10);
  a_disp_full:  assert property (@(posedge clk) disable iff (rst)
                                 (disp_valid != 2'b00) |-> disp_ready);

endmodule

// File: tb/tb_int_iq_age_scheduler.sv
// Bench for int_iq_age_scheduler. The reference model keeps the queue as an
// oldest-first list of slot IDs plus a ready bit per slot; expected outputs for
// each cycle go into a scoreboard queue that a negedge monitor drains.
module tb_int_iq_age_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1, flush = 1'b0;
  logic [1:0] disp_valid = '0, disp_src_ready = '0;
  logic       disp_ready;
  logic [2:0] disp_slot_0, disp_slot_1;
  logic [7:0] wake_mask = '0;
  logic       issue_valid_0, issue_valid_1;
  logic [2:0] issue_slot_0, issue_slot_1;
  logic       issue_accept_0 = 1'b0, issue_accept_1 = 1'b0;
  logic [3:0] occupancy;

  int_iq_age_scheduler dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_src_ready(disp_src_ready),
    .disp_ready(disp_ready), .disp_slot_0(disp_slot_0), .disp_slot_1(disp_slot_1),
    .wake_mask(wake_mask),
    .issue_valid_0(issue_valid_0), .issue_slot_0(issue_slot_0), .issue_accept_0(issue_accept_0),
    .issue_valid_1(issue_valid_1), .issue_slot_1(issue_slot_1), .issue_accept_1(issue_accept_1),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] occ;
    logic       dr;
    logic [2:0] ds0, ds1;
    logic       iv0;
    logic [2:0] is0;
    logic       iv1;
    logic [2:0] is1;
  } exp_t;

  exp_t exp_q[$];
  int   order[$];      // slot IDs, oldest first
  bit   rdy[8];
  bit   mdl_ok = 1'b0;
  int   n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic exp_t predict();
    exp_t e;
    bit   used[8];
    int   nf = 0, nr = 0;
    e = '0;
    foreach (used[i]) used[i] = 1'b0;
    foreach (order[k]) used[order[k]] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!used[i]) begin
        if (nf == 0) e.ds0 = 3'(i);
        else if (nf == 1) e.ds1 = 3'(i);
        nf++;
      end
    end
    foreach (order[k]) begin
      if (rdy[order[k]]) begin
        if (nr == 0) begin e.iv0 = 1'b1; e.is0 = 3'(order[k]); end
        else if (nr == 1) begin e.iv1 = 1'b1; e.is1 = 3'(order[k]); end
        nr++;
      end
    end
    e.occ = 4'(order.size());
    e.dr  = (8 - order.size()) >= 2;
    return e;
  endfunction

  task automatic drop(input int s);
    for (int k = 0; k < order.size(); k++)
      if (order[k] == s) begin order.delete(k); break; end
    rdy[s] = 1'b0;
  endtask

  // One clock: record the expected outputs of the current state, drive the
  // inputs, advance the model, then wait until just after the edge.
  task automatic step(input bit r, input bit fl, input bit [1:0] dv, input bit [1:0] dsr,
                      input bit [7:0] wk, input bit a0, input bit a1);
    exp_t e;
    e = predict();
    if (mdl_ok) exp_q.push_back(e);
    rst = r; flush = fl; disp_valid = dv; disp_src_ready = dsr;
    wake_mask = wk; issue_accept_0 = a0; issue_accept_1 = a1;
    if (r || fl) begin
      order.delete();
      foreach (rdy[i]) rdy[i] = 1'b0;
      if (r) mdl_ok = 1'b1;
    end else begin
      if (a0 && e.iv0) drop(int'(e.is0));
      if (a1 && e.iv1) drop(int'(e.is1));
      foreach (order[k]) if (wk[order[k]]) rdy[order[k]] = 1'b1;
      if (e.dr && dv[0]) begin order.push_back(int'(e.ds0)); rdy[e.ds0] = dsr[0] | wk[e.ds0]; end
      if (e.dr && dv[1]) begin order.push_back(int'(e.ds1)); rdy[e.ds1] = dsr[1] | wk[e.ds1]; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1, 0, 2'b00, 2'b00, 8'h00, 0, 0);
    step(1, 0, 2'b00, 2'b00, 8'h00, 0, 0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("occupancy",     int'(occupancy),     int'(e.occ));
      chk("disp_ready",    int'(disp_ready),    int'(e.dr));
      chk("disp_slot_0",   int'(disp_slot_0),   int'(e.ds0));
      chk("disp_slot_1",   int'(disp_slot_1),   int'(e.ds1));
      chk("issue_valid_0", int'(issue_valid_0), int'(e.iv0));
      chk("issue_slot_0",  int'(issue_slot_0),  int'(e.is0));
      chk("issue_valid_1", int'(issue_valid_1), int'(e.iv1));
      chk("issue_slot_1",  int'(issue_slot_1),  int'(e.is1));
    end
  end

  initial begin
    exp_t  p;
    bit [1:0] dv;
    // reset state
    do_reset();
    chk("rst_occ", int'(occupancy), 0);
    chk("rst_dr",  int'(disp_ready), 1);
    chk("rst_ds0", int'(disp_slot_0), 0);
    chk("rst_ds1", int'(disp_slot_1), 1);
    chk("rst_iv0", int'(issue_valid_0), 0);
    chk("rst_iv1", int'(issue_valid_1), 0);

    // A,B not ready; C ready at dispatch
    step(0, 0, 2'b11, 2'b00, 8'h00, 0, 0);
    step(0, 0, 2'b01, 2'b01, 8'h00, 0, 0);
    chk("abc_occ", int'(occupancy), 3);
    chk("abc_iv0", int'(issue_valid_0), 1);
    chk("abc_is0", int'(issue_slot_0), 2);
    chk("abc_iv1", int'(issue_valid_1), 0);
    // wake A,B, then accept both ports
    step(0, 0, 2'b00, 2'b00, 8'h03, 0, 0);
    chk("wake_is0", int'(issue_slot_0), 0);
    chk("wake_is1", int'(issue_slot_1), 1);
    step(0, 0, 2'b00, 2'b00, 8'h00, 1, 1);
    chk("acc2_occ", int'(occupancy), 1);
    chk("acc2_is0", int'(issue_slot_0), 2);
    chk("acc2_iv1", int'(issue_valid_1), 0);

    // fill to 8 and drain across the disp_ready boundary
    do_reset();
    repeat (3) step(0, 0, 2'b11, 2'b11, 8'h00, 0, 0);
    chk("fill6_dr", int'(disp_ready), 1);
    step(0, 0, 2'b11, 2'b11, 8'h00, 0, 0);
    chk("fill8_occ", int'(occupancy), 8);
    chk("fill8_dr",  int'(disp_ready), 0);
    step(0, 0, 2'b00, 2'b00, 8'h00, 1, 0);
    chk("occ7_dr", int'(disp_ready), 0);
    step(0, 0, 2'b00, 2'b00, 8'h00, 1, 0);
    chk("occ6_dr", int'(disp_ready), 1);

    // accept on port 1 only
    do_reset();
    step(0, 0, 2'b11, 2'b11, 8'h00, 0, 0);
    step(0, 0, 2'b01, 2'b01, 8'h00, 0, 0);
    step(0, 0, 2'b00, 2'b00, 8'h00, 0, 1);
    chk("p1_occ", int'(occupancy), 2);
    chk("p1_is0", int'(issue_slot_0), 0);
    chk("p1_is1", int'(issue_slot_1), 2);

    // flush beats same-cycle dispatch and issue
    do_reset();
    step(0, 0, 2'b11, 2'b11, 8'h00, 0, 0);
    step(0, 0, 2'b11, 2'b10, 8'h00, 0, 0);
    step(0, 0, 2'b01, 2'b00, 8'h00, 0, 0);
    step(0, 1, 2'b11, 2'b11, 8'hFF, 1, 0);
    chk("fl_occ", int'(occupancy), 0);
    chk("fl_ds0", int'(disp_slot_0), 0);
    chk("fl_ds1", int'(disp_slot_1), 1);
    chk("fl_iv0", int'(issue_valid_0), 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      p = predict();
      case ($urandom_range(0, 2))
        0:       dv = 2'b00;
        1:       dv = 2'b01;
        default: dv = 2'b11;
      endcase
      if (!p.dr) dv = 2'b00;
      if ($urandom_range(0, 299) == 0)
        step(1, 0, 2'b00, 2'b00, 8'h00, 0, 0);
      else
        step(0, $urandom_range(0, 49) == 0, dv, 2'($urandom),
             8'($urandom & $urandom & $urandom),
             $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5);
    end

    @(negedge clk);
    #1;
    chk("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
